// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART transmitter: buffers bursty status writes and
// issues one byte per frame over the tx_data/tx_en/tx_ready handshake.
module uart_tx_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_ready
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              full_reg;
    logic              empty_reg;
    logic              overflow_reg;
    logic [7:0]        tx_data_reg;
    logic              tx_en_reg;
    state_t            state_reg;

    logic push;
    logic pop;

    // A full queue rejects writes even when a pop happens in the same cycle.
    assign push = wr_en && !full_reg;
    assign pop  = (state_reg == IDLE) && !empty_reg && tx_ready;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            tx_data_reg  <= 8'hFF;
            tx_en_reg    <= 1'b0;
            state_reg    <= IDLE;
        end else begin
            overflow_reg <= wr_en && full_reg;
            count_reg    <= count_next;
            full_reg     <= (count_next == DEPTH_CNT);
            empty_reg    <= (count_next == '0);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    tx_en_reg <= 1'b0;
                    if (pop) begin
                        tx_data_reg <= mem[rd_ptr_reg];
                        tx_en_reg   <= 1'b1;
                        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                        state_reg   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // Wait for the transmitter to drop ready so the same
                    // frame can never be mistaken for an idle transmitter.
                    tx_en_reg <= 1'b0;
                    if (!tx_ready) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    tx_en_reg <= 1'b0;
                    if (tx_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    tx_en_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign full     = full_reg;
    assign empty    = empty_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign tx_data  = tx_data_reg;
    assign tx_en    = tx_en_reg;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus pushes expected bytes, a
// monitor pops and checks every tx_en strobe against a busy-transmitter model.
module tb_uart_tx_queue;

    localparam int BUSY = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_ready;

    logic       hold = 1'b0;
    int         busy_cnt = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];

    logic prev_en = 1'b0;
    logic seen_low = 1'b0;
    logic cycled = 1'b1;

    uart_tx_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    // Transmitter model: ready drops one cycle after tx_en and stays low BUSY cycles.
    assign tx_ready = !hold && (busy_cnt == 0);

    always @(posedge clk) begin : xmtr
        logic en_s;
        en_s = tx_en;
        #1;
        if (en_s) busy_cnt = BUSY;
        else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the scoreboard head and follow a ready low->high cycle.
    always @(negedge clk) begin
        if (reset) begin
            prev_en  = 1'b0;
            seen_low = 1'b0;
            cycled   = 1'b1;
        end else begin
            if (tx_en) begin
                check("tx_en_width", {31'd0, prev_en}, 32'd0);
                check("reissue_before_ready_cycle", {31'd0, cycled}, 32'd1);
                check("unexpected_tx", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
                $display("tx byte %02h issued at %0t", tx_data, $time);
                cycled   = 1'b0;
                seen_low = 1'b0;
            end else begin
                if (!tx_ready) seen_low = 1'b1;
                else if (seen_low) cycled = 1'b1;
            end
            prev_en = tx_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_cnt != 0) && n < 1000) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, {31'd0, n < 1000}, 32'd1);
        repeat (3) tick();
        check({name, "_empty"}, {31'd0, empty}, 32'd1);
        check({name, "_count"}, {27'd0, count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'hFF);
        check("rst_tx_en", {31'd0, tx_en}, 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        check("idle_empty", {31'd0, empty}, 32'd1);
        check("idle_tx_data", {24'd0, tx_data}, 32'hFF);
        check("idle_tx_en", {31'd0, tx_en}, 32'd0);

        // Single byte: empty drops next cycle, strobe one cycle after that
        write_byte(8'h41, 1'b1);
        check("single_empty", {31'd0, empty}, 32'd0);
        check("single_count1", {27'd0, count}, 32'd1);
        tick();
        check("single_tx_en", {31'd0, tx_en}, 32'd1);
        check("single_tx_data", {24'd0, tx_data}, 32'h41);
        check("single_count0", {27'd0, count}, 32'd0);
        drain("single");

        // Three back-to-back bytes
        write_byte(8'h31, 1'b1);
        write_byte(8'h32, 1'b1);
        write_byte(8'h33, 1'b1);
        drain("burst3");

        // Fill past full with the transmitter held busy
        hold = 1'b1;
        for (int i = 0; i < 17; i++) begin
            write_byte(8'h50 + 8'(i), i < 16);
            check("fill_overflow", {31'd0, overflow}, {31'd0, i == 16});
            check("fill_count", {27'd0, count}, (i < 16) ? i + 1 : 16);
            if (i == 15) check("fill_full", {31'd0, full}, 32'd1);
        end
        tick();
        check("overflow_pulse_end", {31'd0, overflow}, 32'd0);
        check("full_after_overflow", {31'd0, full}, 32'd1);
        hold = 1'b0;
        drain("fill");

        // Simultaneous write and pop at count=5
        hold = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'h61 + 8'(i), 1'b1);
        check("simul_pre_count", {27'd0, count}, 32'd5);
        hold    = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h66;
        exp_q.push_back(8'h66);
        tick();
        wr_en = 1'b0;
        check("simul_count", {27'd0, count}, 32'd5);
        check("simul_tx_en", {31'd0, tx_en}, 32'd1);
        check("simul_tx_data", {24'd0, tx_data}, 32'h61);
        drain("simul");

        // Reset while waiting on the transmitter with 4 bytes queued
        hold = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'h71 + 8'(i), 1'b1);
        hold = 1'b0;
        repeat (5) tick();
        check("midrst_pre_count", {27'd0, count}, 32'd4);
        check("midrst_ready_low", {31'd0, tx_ready}, 32'd0);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("midrst_count", {27'd0, count}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_tx_en", {31'd0, tx_en}, 32'd0);
        check("midrst_tx_data", {24'd0, tx_data}, 32'hFF);
        reset = 1'b0;
        repeat (50) tick();
        check("postrst_empty", {31'd0, empty}, 32'd1);
        check("postrst_tx_en", {31'd0, tx_en}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
